// File: rtl/csr_regfile_if.sv
// CSR read/write bus between decode/writeback and the machine-mode CSR file.
// Read data is combinational; a write is a single-cycle strobe with no backpressure.
interface csr_regfile_if;
  logic [11:0] csr_raddr;
  logic [63:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;

  modport master (
    output csr_raddr,
    output csr_we,
    output csr_waddr,
    output csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  csr_raddr,
    input  csr_we,
    input  csr_waddr,
    input  csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR file with ecall/mret handling and a registered 1-cycle redirect pulse (no backpressure).
// Reads are combinational; CSR_COUNTER_EN builds mcycle/minstret, otherwise they read 0.
module csr_regfile #(
  parameter logic [63:0] MTVEC_RESET = 64'h0,
  parameter logic [63:0] HART_ID     = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  csr_regfile_if.slave      csr_bus,
  input  logic              ecall_i,
  input  logic              mret_i,
  input  logic [63:0]       trap_pc_i,
  input  logic              inst_retire_i,
  output logic              redirect_valid_o,
  output logic [63:0]       redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        trap_take;
  logic        csr_wr_ok;
  logic [63:0] mcycle_rd;
  logic [63:0] minstret_rd;

  // Traps are only accepted in IDLE; during REDIRECT the pipeline is flushing.
  assign trap_take = (state_q == IDLE) && (ecall_i || mret_i);
  assign csr_wr_ok = csr_bus.csr_we && !trap_take;

  always_comb begin
    state_d          = state_q;
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mscratch_d       = mscratch_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (trap_take) begin
      state_d          = REDIRECT;
      redirect_valid_d = 1'b1;
      if (ecall_i) begin
        mepc_d        = {trap_pc_i[63:2], 2'b00};
        mcause_d      = 64'd11;
        mpie_d        = mie_q;
        mie_d         = 1'b0;
        redirect_pc_d = mtvec_q;
      end else begin
        mie_d         = mpie_q;
        mpie_d        = 1'b1;
        redirect_pc_d = mepc_q;
      end
    end else begin
      state_d = IDLE;
      if (csr_wr_ok) begin
        case (csr_bus.csr_waddr)
          ADDR_MSTATUS: begin
            mie_d  = csr_bus.csr_wdata[3];
            mpie_d = csr_bus.csr_wdata[7];
          end
          ADDR_MTVEC:    mtvec_d    = {csr_bus.csr_wdata[63:2], 2'b00};
          ADDR_MSCRATCH: mscratch_d = csr_bus.csr_wdata;
          ADDR_MEPC:     mepc_d     = {csr_bus.csr_wdata[63:2], 2'b00};
          ADDR_MCAUSE:   mcause_d   = csr_bus.csr_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mtvec_q          <= MTVEC_RESET & ~64'h3;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mscratch_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      mie_q            <= mie_d;
      mpie_q           <= mpie_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mscratch_q       <= mscratch_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  // A software write wins over the increment in the same cycle.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, inst_retire_i};
    if (csr_wr_ok && (csr_bus.csr_waddr == ADDR_MCYCLE)) begin
      mcycle_d = csr_bus.csr_wdata;
    end
    if (csr_wr_ok && (csr_bus.csr_waddr == ADDR_MINSTRET)) begin
      minstret_d = csr_bus.csr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mcycle_rd   = mcycle_q;
  assign minstret_rd = minstret_q;
`else
  logic unused_inst_retire;
  assign unused_inst_retire = inst_retire_i;
  assign mcycle_rd          = '0;
  assign minstret_rd        = '0;
`endif

  always_comb begin
    csr_bus.csr_rdata = '0;
    case (csr_bus.csr_raddr)
      ADDR_MSTATUS:  csr_bus.csr_rdata = 64'h1800 | {56'd0, mpie_q, 3'b000, mie_q, 3'b000};
      ADDR_MTVEC:    csr_bus.csr_rdata = mtvec_q;
      ADDR_MSCRATCH: csr_bus.csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_bus.csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_bus.csr_rdata = mcause_q;
      ADDR_MCYCLE:   csr_bus.csr_rdata = mcycle_rd;
      ADDR_MINSTRET: csr_bus.csr_rdata = minstret_rd;
      ADDR_MHARTID:  csr_bus.csr_rdata = HART_ID;
      default:       csr_bus.csr_rdata = '0;
    endcase
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed checks from the CSR rules plus a randomized run
// compared every cycle against a behavioural CSR model.
module tb_csr_regfile;
  localparam logic [63:0] TB_MTVEC_RESET = 64'h8000_0003;
  localparam logic [63:0] TB_HART_ID     = 64'h7;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall;
  logic        mret;
  logic [63:0] trap_pc;
  logic        inst_retire;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  csr_regfile_if bus ();

  csr_regfile #(
    .MTVEC_RESET (TB_MTVEC_RESET),
    .HART_ID     (TB_HART_ID)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .csr_bus          (bus),
    .ecall_i          (ecall),
    .mret_i           (mret),
    .trap_pc_i        (trap_pc),
    .inst_retire_i    (inst_retire),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: architectural CSR contents plus "a redirect pulse is showing".
  logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch, m_mcycle, m_minstret;
  logic        m_rv;
  logic [63:0] m_rpc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus | 64'h1800;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
`ifdef CSR_COUNTER_EN
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
`endif
      12'hF14: return TB_HART_ID;
      default: return 64'h0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [63:0] d);
    case (a)
      12'h300: m_mstatus  = d & 64'h88;
      12'h305: m_mtvec    = d & ~64'h3;
      12'h340: m_mscratch = d;
      12'h341: m_mepc     = d & ~64'h3;
      12'h342: m_mcause   = d;
`ifdef CSR_COUNTER_EN
      12'hB00: m_mcycle   = d;
      12'hB02: m_minstret = d;
`endif
      default: ;
    endcase
  endtask

  // Applies the architectural effect of one clock edge using the inputs held during that cycle.
  task automatic model_update();
    logic mie, mpie;
    if (rst) begin
      m_mstatus = 0; m_mtvec = TB_MTVEC_RESET & ~64'h3; m_mepc = 0; m_mcause = 0;
      m_mscratch = 0; m_mcycle = 0; m_minstret = 0; m_rv = 0; m_rpc = 0;
    end else begin
      mie  = m_mstatus[3];
      mpie = m_mstatus[7];
      m_mcycle = m_mcycle + 1;
      if (inst_retire) m_minstret = m_minstret + 1;
      if (!m_rv && ecall) begin
        m_rpc     = m_mtvec;
        m_rv      = 1;
        m_mepc    = trap_pc & ~64'h3;
        m_mcause  = 64'd11;
        m_mstatus = mie ? 64'h80 : 64'h0;
      end else if (!m_rv && mret) begin
        m_rpc     = m_mepc;
        m_rv      = 1;
        m_mstatus = 64'h80 | (mpie ? 64'h8 : 64'h0);
      end else begin
        m_rv = 0;
        if (bus.csr_we) m_write(bus.csr_waddr, bus.csr_wdata);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ecall = 0; mret = 0; trap_pc = 0; inst_retire = 0;
    bus.csr_we = 0; bus.csr_waddr = 0; bus.csr_wdata = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    bus.csr_we = 1; bus.csr_waddr = a; bus.csr_wdata = d;
    tick();
    bus.csr_we = 0;
  endtask

  task automatic look(input string name, input logic [11:0] a, input logic [63:0] exp);
    bus.csr_raddr = a;
    #1;
    chk(name, bus.csr_rdata, exp);
  endtask

  function automatic logic [11:0] pick_addr(input int k);
    case (k)
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h340;
      3: return 12'h341;
      4: return 12'h342;
      5: return 12'hB00;
      6: return 12'hB02;
      7: return 12'hF14;
      default: return 12'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
      if (m_rv) chk("cmp_redirect_pc", redirect_pc, m_rpc);
      chk("cmp_rdata", bus.csr_rdata, m_read(bus.csr_raddr));
    end
  end

  initial begin
    logic [63:0] base;
    rst = 1; bus.csr_raddr = 12'h305;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    cmp_en = 1;

    @(negedge clk);
    chk("reset_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    look("reset_mtvec", 12'h305, 64'h8000_0000);
    look("reset_mstatus", 12'h300, 64'h1800);

    wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk); look("mstatus_mask", 12'h300, 64'h1888);
    wr(12'h340, 64'hDEAD_BEEF_0000_1234);
    @(negedge clk); look("mscratch_full", 12'h340, 64'hDEAD_BEEF_0000_1234);
    wr(12'hF14, 64'h1234);
    @(negedge clk); look("mhartid_ro", 12'hF14, TB_HART_ID);
    wr(12'h305, 64'h103);
    @(negedge clk); look("mtvec_low_bits", 12'h305, 64'h100);

    ecall = 1; trap_pc = 64'h2006;
    tick();
    ecall = 0; trap_pc = 0; bus.csr_raddr = 12'h341;
    @(negedge clk);
    chk("ecall_rv", {63'd0, redirect_valid}, 64'd1);
    chk("ecall_rpc", redirect_pc, 64'h100);
    look("ecall_mepc", 12'h341, 64'h2004);
    look("ecall_mcause", 12'h342, 64'd11);
    look("ecall_mstatus", 12'h300, 64'h1880);
    tick();
    @(negedge clk); chk("ecall_pulse_end", {63'd0, redirect_valid}, 64'd0);

    mret = 1;
    tick();
    @(negedge clk);
    chk("mret_rv", {63'd0, redirect_valid}, 64'd1);
    chk("mret_rpc", redirect_pc, 64'h2004);
    look("mret_mstatus", 12'h300, 64'h1888);
    tick();
    mret = 0;
    @(negedge clk); chk("mret_in_redirect_ignored", {63'd0, redirect_valid}, 64'd0);
    tick();
    @(negedge clk); chk("mret_no_second_pulse", {63'd0, redirect_valid}, 64'd0);

    ecall = 1; mret = 1; trap_pc = 64'h3000;
    bus.csr_we = 1; bus.csr_waddr = 12'h340; bus.csr_wdata = 64'h55;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("both_rv", {63'd0, redirect_valid}, 64'd1);
    chk("both_rpc", redirect_pc, 64'h100);
    look("both_mscratch_kept", 12'h340, 64'hDEAD_BEEF_0000_1234);
    look("both_ecall_path", 12'h300, 64'h1880);
    tick();
    @(negedge clk); chk("both_single_pulse", {63'd0, redirect_valid}, 64'd0);

`ifdef CSR_COUNTER_EN
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk); look("mcycle_load", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    @(negedge clk); look("mcycle_max", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    @(negedge clk); look("mcycle_wrap", 12'hB00, 64'h0);
    bus.csr_raddr = 12'hB02;
    #1;
    base = m_minstret;
    for (int i = 0; i < 3; i++) begin
      inst_retire = 1;
      tick();
    end
    inst_retire = 0;
    @(negedge clk); look("minstret_plus3", 12'hB02, base + 64'd3);
`else
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
    inst_retire = 1;
    tick();
    inst_retire = 0;
    @(negedge clk);
    look("mcycle_absent", 12'hB00, 64'h0);
    look("minstret_absent", 12'hB02, 64'h0);
    base = 0;
`endif

    ecall = 1; trap_pc = 64'h4000;
    tick();
    ecall = 0; rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("reset_mid_redirect", {63'd0, redirect_valid}, 64'd0);
    look("reset_mid_mtvec", 12'h305, 64'h8000_0000);

    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      ecall          = ($urandom_range(0, 7) == 0);
      mret           = ($urandom_range(0, 7) == 0);
      trap_pc        = {$urandom, $urandom};
      inst_retire    = $urandom_range(0, 1) == 1;
      bus.csr_we     = $urandom_range(0, 1) == 1;
      bus.csr_waddr  = pick_addr($urandom_range(0, 8));
      bus.csr_wdata  = {$urandom, $urandom};
      bus.csr_raddr  = pick_addr($urandom_range(0, 8));
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();
    @(negedge clk);
    cmp_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
